// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: prescaler, start/stop/clear FSM and a rippling BCD digit cascade with overflow hold.
// Optional lap-freeze display enabled by defining LAP_HOLD_EN.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  running,
  output logic                  ovf,
  output logic                  tick,
  output logic                  lap_active
);

  localparam int              PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_OVF} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [4*DIGITS-1:0]   dig_q, dig_d, dig_inc;
  logic                  tick_q;
  logic                  count_en, wrap, all_nine;

  // Whole-cascade increment in one step: every trailing 9 wraps, the first non-9 digit bumps.
  always_comb begin : bcd_incr
    logic carry;
    carry    = 1'b1;
    all_nine = 1'b1;
    dig_inc  = dig_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k +: 4] != 4'd9) all_nine = 1'b0;
      if (carry) begin
        if (dig_q[4*k +: 4] == 4'd9) begin
          dig_inc[4*k +: 4] = 4'd0;
        end else begin
          dig_inc[4*k +: 4] = dig_q[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_en = (state_q == ST_RUN) && !stop && !clear;
    wrap     = count_en && (pre_q == PMAX);

    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_PAUSE: if (start && !stop) state_d = ST_RUN;
      ST_RUN: begin
        if (stop)                  state_d = ST_PAUSE;
        else if (wrap && all_nine) state_d = ST_OVF;
      end
      default: state_d = state_q;
    endcase
    if (clear) state_d = ST_IDLE;

    pre_d = pre_q;
    if (count_en) pre_d = wrap ? '0 : pre_q + PW'(1);
    if (clear)    pre_d = '0;

    dig_d = dig_q;
    if (wrap && !all_nine) dig_d = dig_inc;
    if (clear)             dig_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      dig_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dig_q   <= dig_d;
      tick_q  <= wrap;
    end
  end

  assign running = (state_q == ST_RUN);
  assign ovf     = (state_q == ST_OVF);
  assign tick    = tick_q;

`ifdef LAP_HOLD_EN
  logic                lap_q, lap_act_q, lap_act_d;
  logic [4*DIGITS-1:0] lap_val_q, lap_val_d;

  always_comb begin
    lap_act_d = lap_act_q;
    lap_val_d = lap_val_q;
    if (clear || (state_d == ST_OVF && state_q != ST_OVF)) begin
      lap_act_d = 1'b0;
    end else if (lap && !lap_q) begin
      if (lap_act_q) begin
        lap_act_d = 1'b0;
      end else if (state_q == ST_RUN || state_q == ST_PAUSE) begin
        lap_act_d = 1'b1;
        lap_val_d = dig_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lap_q     <= 1'b0;
      lap_act_q <= 1'b0;
      lap_val_q <= '0;
    end else begin
      lap_q     <= lap;
      lap_act_q <= lap_act_d;
      lap_val_q <= lap_val_d;
    end
  end

  assign bcd_out    = lap_act_q ? lap_val_q : dig_q;
  assign lap_active = lap_act_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign bcd_out    = dig_q;
  assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: integer-count reference model, directed scenarios plus random commands.
module tb_bcd_stopwatch_ctrl;
  localparam int D      = 2;
  localparam int P      = 4;
  localparam int VW     = 4*D + 4;
  localparam int MAXCNT = 10**D - 1;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_OVF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, clear, lap;
  logic [4*D-1:0] bcd_out;
  logic running, ovf, tick, lap_active;
  logic [VW-1:0] dut_vec;
  assign dut_vec = {bcd_out, running, ovf, tick, lap_active};

  bcd_stopwatch_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .bcd_out(bcd_out), .running(running), .ovf(ovf), .tick(tick), .lap_active(lap_active)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: plain decimal count, stopwatch mode and elapsed cycles in current tick
  int m_state, m_cnt, m_pre, m_lap_val;
  bit m_tick, m_lap_act, m_lap_prev;

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] b;
    int x;
    x = v;
    b = '0;
    for (int k = 0; k < D; k++) begin
      b[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    int shown;
    shown = m_lap_act ? m_lap_val : m_cnt;
    return {to_bcd(shown), 1'(m_state == S_RUN), 1'(m_state == S_OVF), 1'(m_tick), 1'(m_lap_act)};
  endfunction

  task automatic drive(input logic r, input logic s, input logic p, input logic c, input logic l);
    int ns;
    bit en, wrapped, full;
    rst = r; start = s; stop = p; clear = c; lap = l;
    @(posedge clk);
    if (!r) begin
      m_state = S_IDLE; m_cnt = 0; m_pre = 0; m_tick = 0; m_lap_act = 0; m_lap_val = 0;
    end else begin
      en      = (m_state == S_RUN) && !p && !c;
      wrapped = en && (m_pre == P - 1);
      full    = (m_cnt == MAXCNT);
      ns      = m_state;
      if (c) ns = S_IDLE;
      else if ((m_state == S_IDLE || m_state == S_PAUSE) && s && !p) ns = S_RUN;
      else if (m_state == S_RUN && p) ns = S_PAUSE;
      else if (m_state == S_RUN && wrapped && full) ns = S_OVF;
`ifdef LAP_HOLD_EN
      if (c || (ns == S_OVF && m_state != S_OVF)) m_lap_act = 0;
      else if (l && !m_lap_prev) begin
        if (m_lap_act) m_lap_act = 0;
        else if (m_state == S_RUN || m_state == S_PAUSE) begin
          m_lap_act = 1;
          m_lap_val = m_cnt;
        end
      end
`endif
      if (c) m_pre = 0;
      else if (en) m_pre = (m_pre + 1) % P;
      if (c) m_cnt = 0;
      else if (wrapped && !full) m_cnt = m_cnt + 1;
      m_tick  = wrapped;
      m_state = ns;
    end
    m_lap_prev = r ? l : 1'b0;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    n_cmp++;
    if (dut_vec !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, {VW{1'b0}});
    end
    drive(1, 0, 0, 0, 0);
    n_cmp++;
    if (running !== 1'b0 || bcd_out !== '0) begin
      n_err++; $display("FAIL reset_idle: got running=%b bcd=%h expected running=0 bcd=00", running, bcd_out);
    end
  endtask

  task automatic test_basic_count();
    drive(1, 1, 0, 0, 0);
    n_cmp++;
    if (running !== 1'b1) begin
      n_err++; $display("FAIL basic_running_e0: got %b expected 1", running);
    end
    for (int i = 1; i <= 44; i++) begin
      drive(1, 0, 0, 0, 0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL basic_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (i == 4 || i == 40) begin
        n_cmp++;
        if (bcd_out !== ((i == 4) ? 8'h01 : 8'h10)) begin
          n_err++; $display("FAIL basic_value E0+%0d: got %h expected %h", i, bcd_out, (i == 4) ? 8'h01 : 8'h10);
        end
      end
    end
  endtask

  task automatic test_pause_resume();
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 100 && m_cnt != 7; i++) drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 0);
      n_cmp++;
      if (bcd_out !== 8'h07 || tick !== 1'b0 || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL pause_hold cyc %0d: got %h expected %h (bcd 07, tick 0)", i, dut_vec, exp_vec());
      end
    end
    drive(1, 1, 0, 0, 0);
    for (int i = 1; i <= 2; i++) begin
      drive(1, 0, 0, 0, 0);
      n_cmp++;
      if (bcd_out !== ((i == 2) ? 8'h08 : 8'h07) || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL resume_remaining cyc %0d: got %h expected bcd %h", i, bcd_out, (i == 2) ? 8'h08 : 8'h07);
      end
    end
  endtask

  task automatic test_overflow();
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 600 && m_state != S_OVF; i++) begin
      drive(1, 0, 0, 0, 0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL ovf_run cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (ovf !== 1'b1 || running !== 1'b0 || bcd_out !== 8'h99 || tick !== 1'b1) begin
      n_err++; $display("FAIL ovf_entry: got ovf=%b run=%b bcd=%h tick=%b expected 1 0 99 1", ovf, running, bcd_out, tick);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1'($urandom_range(0, 1)), 0, 0);
      n_cmp++;
      if (ovf !== 1'b1 || running !== 1'b0 || bcd_out !== 8'h99) begin
        n_err++; $display("FAIL ovf_hold cyc %0d: got ovf=%b run=%b bcd=%h expected 1 0 99", i, ovf, running, bcd_out);
      end
    end
    drive(1, 0, 0, 1, 0);
    n_cmp++;
    if (ovf !== 1'b0 || running !== 1'b0 || bcd_out !== 8'h00) begin
      n_err++; $display("FAIL ovf_clear: got ovf=%b run=%b bcd=%h expected 0 0 00", ovf, running, bcd_out);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0);
      n_cmp++;
      if (running !== 1'b0) begin
        n_err++; $display("FAIL prio_idle_startstop cyc %0d: got running=%b expected 0", i, running);
      end
    end
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 200 && m_cnt != 35; i++) drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 0);
    n_cmp++;
    if (running !== 1'b0 || bcd_out !== 8'h00 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL prio_clear_wins: got %h expected %h", dut_vec, exp_vec());
    end
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 200 && m_cnt != 35; i++) drive(1, 0, 0, 0, 0);
    n_cmp++;
    if (bcd_out !== 8'h35) begin
      n_err++; $display("FAIL prio_reach_35: got %h expected 35", bcd_out);
    end
    drive(0, 1, 0, 0, 0);
    n_cmp++;
    if (dut_vec !== '0) begin
      n_err++; $display("FAIL prio_reset_midrun: got %h expected 0", dut_vec);
    end
  endtask

  task automatic test_random();
    logic r, s, p, c, l;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 6) == 0);
      drive(r, s, p, c, l);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

`ifdef LAP_HOLD_EN
  task automatic test_lap();
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 100 && m_cnt != 12; i++) drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    n_cmp++;
    if (lap_active !== 1'b1 || bcd_out !== 8'h12) begin
      n_err++; $display("FAIL lap_capture: got act=%b bcd=%h expected 1 12", lap_active, bcd_out);
    end
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 0, 0);
      n_cmp++;
      if (bcd_out !== 8'h12 || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL lap_frozen cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    drive(1, 0, 0, 0, 1);
    n_cmp++;
    if (lap_active !== 1'b0 || bcd_out !== 8'h14) begin
      n_err++; $display("FAIL lap_release: got act=%b bcd=%h expected 0 14", lap_active, bcd_out);
    end
    drive(1, 0, 0, 0, 0);
  endtask
`else
  task automatic test_lap();
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 0, 0, 1'(i % 3 == 0));
      n_cmp++;
      if (lap_active !== 1'b0 || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL lap_ignored cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    m_state = S_IDLE; m_cnt = 0; m_pre = 0; m_lap_val = 0;
    m_tick = 0; m_lap_act = 0; m_lap_prev = 0;
    test_reset();
    test_basic_count();
    test_pause_resume();
    test_overflow();
    test_priority();
    test_lap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
